regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports.
REQ-004 SHALL have parameter NWRITE, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rd_addr  input  NREAD*AW  read addresses; port i uses slice [i*AW +: AW].
REQ-009 SHALL have port rd_data  output  NREAD*XLEN  read data per port.
REQ-010 SHALL have port rd_busy  output  NREAD  1 = read register has a pending write.
REQ-011 SHALL have port wr_en  input  NWRITE  write enables (writeback).
REQ-012 SHALL have port wr_addr  input  NWRITE*AW  write addresses.
REQ-013 SHALL have port wr_data  input  NWRITE*XLEN  write data.
REQ-014 SHALL have port iss_valid  input  1  request to mark iss_rd pending.
REQ-015 SHALL have port iss_rd  input  AW  destination register of the issuing instruction.
REQ-016 SHALL have port iss_ready  output  1  issue accepted this cycle.
REQ-017 SHALL have port flush  input  1  clear all pending bits.

Function
REQ-018 SHALL hold an NREGS x XLEN register array and an NREGS-bit busy vector.
REQ-019 SHALL hard-wire register 0: reads return 0, busy[0] always 0, writes and issues to 0 have no effect on state.
REQ-020 SHALL drive rd_data combinationally from the array (zero latency); a write is visible to a read in the cycle after the write edge.
REQ-021 SHALL, when BYPASS=1 and some enabled write port targets a nonzero rd_addr, return that port's wr_data on rd_data and 0 on rd_busy in the same cycle.
REQ-022 SHALL resolve multiple enabled write ports to the same address: highest port index wins, for both the array update and the bypass value.
REQ-023 SHALL set busy[r] on posedge when iss_valid and iss_ready and r = iss_rd != 0.
REQ-024 SHALL clear busy[r] on posedge when any enabled write port targets r.
REQ-025 SHALL, when an accepted issue and a write target the same register in one cycle, update the array with the write data and leave busy set (issue wins).
REQ-026 SHALL drive iss_ready = !busy[iss_rd] or iss_rd == 0 or a write to iss_rd occurs this cycle; iss_ready is independent of iss_valid.
REQ-027 SHALL ignore iss_valid when iss_ready is 0; no state change.
REQ-028 SHALL, on flush, clear every busy bit on posedge, overriding same-cycle issues; same-cycle writes still update the array.
REQ-029 SHALL drive rd_busy[i] = busy[rd_addr[i]], except as modified by REQ-021.
REQ-030 SHALL not forward when BYPASS=0; rd_data returns the old value and rd_busy returns the stored bit during the write cycle.

Reset
REQ-031 SHALL, on posedge with rst=1, set all registers to 0 and all busy bits to 0; rst overrides writes, issues and flush.
REQ-032 SHALL drive rd_data = 0, rd_busy = 0 and iss_ready = 1 in the cycle after reset is applied, for any address.
REQ-033 SHALL discard any pending writes and issues on reset asserted mid-operation; no partial state update.

Verification
REQ-034 SHALL cover this scenario: reset, then write port0 addr 5 = 0xDEADBEEF; next cycle read port1 addr 5 -> 0xDEADBEEF, rd_busy = 0.
REQ-035 SHALL cover this scenario: write addr 0 = 0x1234 -> read addr 0 returns 0; issue iss_rd = 0 -> iss_ready = 1 and busy stays 0.
REQ-036 SHALL cover this scenario: issue iss_rd = 7, then re-issue 7 -> iss_ready = 0; write 7 = 0xA5 with BYPASS=1 -> same-cycle read 7 gives 0xA5, busy 0, iss_ready = 1.
REQ-037 SHALL cover this scenario: ports 0 and 1 both write addr 3 (0x11, 0x22) -> bypass and stored value are both 0x22.
REQ-038 SHALL cover this scenario: issue 9 together with a write to 9 = 0x55 -> next cycle read 9 = 0x55, rd_busy = 1.
REQ-039 SHALL cover this scenario: busy set on 4 and 6, assert flush plus issue 8 -> next cycle all busy = 0; then assert rst -> all reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a per-register busy (pending-write) scoreboard.
// Register 0 is hard-wired to zero and is never marked busy.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREAD*$clog2(NREGS)-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]              rd_data,
    output logic [NREAD-1:0]                   rd_busy,
    input  logic [NWRITE-1:0]                  wr_en,
    input  logic [NWRITE*$clog2(NREGS)-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]             wr_data,
    input  logic                               iss_valid,
    input  logic [$clog2(NREGS)-1:0]           iss_rd,
    output logic                               iss_ready,
    input  logic                               flush
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;
    logic             iss_accept;

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < int'(NWRITE); j++) begin
            if (wr_en[j]) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Read ports; later write ports override earlier ones in the bypass path.
    always_comb begin
        logic [AW-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            ra = rd_addr[i*AW +: AW];
            if (ra != '0) begin
                rd_data[i*XLEN +: XLEN] = regs_q[ra];
                rd_busy[i]              = busy_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < int'(NWRITE); j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                            rd_busy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign iss_ready  = (iss_rd == '0) || !busy_q[iss_rd] || wr_hit[iss_rd];
    assign iss_accept = iss_valid && iss_ready && (iss_rd != '0);

    // Writeback clears, issue sets (so issue wins on a collision), flush clears all.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (iss_accept) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int j = 0; j < int'(NWRITE); j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end
endmodule
